// File: rtl/axis_packet_buffer_pkg.sv
// Shared types and helpers for the AXI-Stream store-and-forward packet buffer.
package axis_packet_buffer_pkg;

  // Buffer controller states: capture, replay, wait for enable.
  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_FILL  = 2'd1,
    ST_DRAIN = 2'd2
  } state_e;

  // Byte-strobe width for a given tdata width.
  function automatic int unsigned strb_width(input int unsigned data_width);
    return data_width / 8;
  endfunction

endpackage

// File: rtl/axis_buf_ram.sv
// Simple dual-port beat store: synchronous write, asynchronous read, contents never cleared.
module axis_buf_ram #(
  parameter int unsigned WORD_WIDTH = 36,
  parameter int unsigned DEPTH      = 64,
  parameter int unsigned ADDR_WIDTH = 6
) (
  input  logic                  clk,
  input  logic                  wr_en,
  input  logic [ADDR_WIDTH-1:0] wr_addr,
  input  logic [WORD_WIDTH-1:0] wr_data,
  input  logic [ADDR_WIDTH-1:0] rd_addr,
  output logic [WORD_WIDTH-1:0] rd_data_c
);

  logic [WORD_WIDTH-1:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (wr_en) mem[wr_addr] <= wr_data;
  end

  assign rd_data_c = mem[rd_addr];

endmodule

// File: rtl/axis_packet_buffer.sv
// Captures one AXI-Stream packet into local memory, then replays it repeat_cnt+1 times
// with tlast regenerated on the final beat of every replay.
module axis_packet_buffer
  import axis_packet_buffer_pkg::*;
#(
  parameter int unsigned DATA_WIDTH   = 32,
  parameter int unsigned MEM_SIZE     = 64,
  parameter int unsigned ADDR_WIDTH   = 6,
  parameter int unsigned REPEAT_WIDTH = 4
) (
  input  logic                      axis_aclk,
  input  logic                      axis_aresetn,
  input  logic                      enable,
  input  logic [REPEAT_WIDTH-1:0]   repeat_cnt,
  input  logic [DATA_WIDTH-1:0]     s_axis_tdata,
  input  logic [DATA_WIDTH/8-1:0]   s_axis_tstrb,
  input  logic                      s_axis_tvalid,
  input  logic                      s_axis_tlast,
  output logic                      s_axis_tready,
  output logic [DATA_WIDTH-1:0]     m_axis_tdata,
  output logic [DATA_WIDTH/8-1:0]   m_axis_tstrb,
  output logic                      m_axis_tvalid,
  output logic                      m_axis_tlast,
  input  logic                      m_axis_tready,
  output logic [ADDR_WIDTH:0]       pkt_len,
  output logic                      busy,
  output logic                      overflow
);

  localparam int unsigned STRB_W = strb_width(DATA_WIDTH);
  localparam int unsigned WORD_W = DATA_WIDTH + STRB_W;
  localparam int unsigned LEN_W  = ADDR_WIDTH + 1;

  state_e state_q, state_d;

  logic [ADDR_WIDTH-1:0]   wr_ptr_q, rd_ptr_q;
  logic [LEN_W-1:0]        pkt_len_q;
  logic [REPEAT_WIDTH-1:0] rep_lat_q, rep_cnt_q;
  logic                    armed_q, issued_q, overflow_q;
  logic [DATA_WIDTH-1:0]   m_data_q;
  logic [STRB_W-1:0]       m_strb_q;
  logic                    m_tvalid_q, m_tlast_q;

  logic                    s_hs_c, wr_at_end_c, rd_last_c, last_rep_c;
  logic                    start_c, wr_en_c, fill_end_c, load_c, drain_end_c;
  logic [WORD_W-1:0]       rd_data_c;

  axis_buf_ram #(
    .WORD_WIDTH (WORD_W),
    .DEPTH      (MEM_SIZE),
    .ADDR_WIDTH (ADDR_WIDTH)
  ) u_ram (
    .clk       (axis_aclk),
    .wr_en     (wr_en_c),
    .wr_addr   (wr_ptr_q),
    .wr_data   ({s_axis_tstrb, s_axis_tdata}),
    .rd_addr   (rd_ptr_q),
    .rd_data_c (rd_data_c)
  );

  assign s_axis_tready = (state_q == ST_FILL) && enable;
  assign s_hs_c        = s_axis_tready && s_axis_tvalid;
  assign wr_at_end_c   = (wr_ptr_q == ADDR_WIDTH'(MEM_SIZE - 1));
  assign rd_last_c     = ({1'b0, rd_ptr_q} == (pkt_len_q - LEN_W'(1)));
  assign last_rep_c    = (rep_cnt_q == rep_lat_q);

  // State register.
  always_ff @(posedge axis_aclk or negedge axis_aresetn) begin
    if (!axis_aresetn) state_q <= ST_IDLE;
    else               state_q <= state_d;
  end

  // Next-state logic.
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE:  if (start_c)     state_d = ST_FILL;
      ST_FILL:  if (fill_end_c)  state_d = ST_DRAIN;
      ST_DRAIN: if (drain_end_c) state_d = ST_IDLE;
      default:                   state_d = ST_IDLE;
    endcase
  end

  // Per-state control strobes for the datapath.
  always_comb begin
    start_c     = 1'b0;
    wr_en_c     = 1'b0;
    fill_end_c  = 1'b0;
    load_c      = 1'b0;
    drain_end_c = 1'b0;
    case (state_q)
      ST_IDLE: start_c = enable;
      ST_FILL: begin
        wr_en_c    = s_hs_c;
        fill_end_c = s_hs_c && (s_axis_tlast || wr_at_end_c);
      end
      ST_DRAIN: begin
        load_c      = armed_q && !issued_q && (!m_tvalid_q || m_axis_tready);
        drain_end_c = m_tvalid_q && m_axis_tready && m_tlast_q && issued_q;
      end
      default: ;
    endcase
  end

  // Capture side: write pointer, length, overflow flag and replay count latch.
  always_ff @(posedge axis_aclk or negedge axis_aresetn) begin
    if (!axis_aresetn) begin
      wr_ptr_q   <= '0;
      pkt_len_q  <= '0;
      overflow_q <= 1'b0;
      rep_lat_q  <= '0;
    end else begin
      if (start_c) begin
        wr_ptr_q   <= '0;
        overflow_q <= 1'b0;
        rep_lat_q  <= repeat_cnt;
      end else if (wr_en_c) begin
        wr_ptr_q <= wr_ptr_q + ADDR_WIDTH'(1);
      end
      if (fill_end_c) begin
        pkt_len_q  <= LEN_W'(wr_ptr_q) + LEN_W'(1);
        overflow_q <= !s_axis_tlast;
      end
    end
  end

  // Replay side; armed_q inserts one turnaround cycle after the final input beat.
  always_ff @(posedge axis_aclk or negedge axis_aresetn) begin
    if (!axis_aresetn) begin
      rd_ptr_q   <= '0;
      rep_cnt_q  <= '0;
      armed_q    <= 1'b0;
      issued_q   <= 1'b0;
      m_data_q   <= '0;
      m_strb_q   <= '0;
      m_tvalid_q <= 1'b0;
      m_tlast_q  <= 1'b0;
    end else begin
      if (fill_end_c) begin
        rd_ptr_q  <= '0;
        rep_cnt_q <= '0;
        armed_q   <= 1'b0;
        issued_q  <= 1'b0;
      end else if (state_q == ST_DRAIN && !armed_q) begin
        armed_q <= 1'b1;
      end
      if (load_c) begin
        m_data_q   <= rd_data_c[DATA_WIDTH-1:0];
        m_strb_q   <= rd_data_c[WORD_W-1:DATA_WIDTH];
        m_tvalid_q <= 1'b1;
        m_tlast_q  <= rd_last_c;
        if (rd_last_c) begin
          rd_ptr_q <= '0;
          if (last_rep_c) issued_q  <= 1'b1;
          else            rep_cnt_q <= rep_cnt_q + REPEAT_WIDTH'(1);
        end else begin
          rd_ptr_q <= rd_ptr_q + ADDR_WIDTH'(1);
        end
      end else if (m_tvalid_q && m_axis_tready) begin
        m_tvalid_q <= 1'b0;
        m_tlast_q  <= 1'b0;
      end
    end
  end

  assign m_axis_tdata  = m_data_q;
  assign m_axis_tstrb  = m_strb_q;
  assign m_axis_tvalid = m_tvalid_q;
  assign m_axis_tlast  = m_tlast_q;
  assign pkt_len       = pkt_len_q;
  assign busy          = (state_q != ST_IDLE);
  assign overflow      = overflow_q;

endmodule

// File: tb/tb_axis_packet_buffer.sv
// Self-checking bench for axis_packet_buffer: random packets against a queue-based replay model.
module tb_axis_packet_buffer;

  localparam int unsigned DW  = 32;
  localparam int unsigned SW  = 4;
  localparam int unsigned MEM = 64;
  localparam int unsigned AW  = 6;
  localparam int unsigned RW  = 4;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          enable = 1'b0;
  logic [RW-1:0] repeat_cnt = '0;
  logic [DW-1:0] s_tdata = '0;
  logic [SW-1:0] s_tstrb = '0;
  logic          s_tvalid = 1'b0;
  logic          s_tlast = 1'b0;
  logic          s_tready;
  logic [DW-1:0] m_tdata;
  logic [SW-1:0] m_tstrb;
  logic          m_tvalid;
  logic          m_tlast;
  logic          m_tready = 1'b1;
  logic [AW:0]   pkt_len;
  logic          busy;
  logic          overflow;

  int n_asserts = 0;
  int n_fails   = 0;
  int tr_mode   = 0;

  logic [63:0] in_q[$];
  logic [63:0] exp_q[$];
  logic [63:0] obs_q[$];

  always #5 clk = ~clk;

  axis_packet_buffer #(
    .DATA_WIDTH   (DW),
    .MEM_SIZE     (MEM),
    .ADDR_WIDTH   (AW),
    .REPEAT_WIDTH (RW)
  ) dut (
    .axis_aclk     (clk),
    .axis_aresetn  (rst_n),
    .enable        (enable),
    .repeat_cnt    (repeat_cnt),
    .s_axis_tdata  (s_tdata),
    .s_axis_tstrb  (s_tstrb),
    .s_axis_tvalid (s_tvalid),
    .s_axis_tlast  (s_tlast),
    .s_axis_tready (s_tready),
    .m_axis_tdata  (m_tdata),
    .m_axis_tstrb  (m_tstrb),
    .m_axis_tvalid (m_tvalid),
    .m_axis_tlast  (m_tlast),
    .m_axis_tready (m_tready),
    .pkt_len       (pkt_len),
    .busy          (busy),
    .overflow      (overflow)
  );

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_asserts++;
    assert (obs === exp) else begin
      n_fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [63:0] pack_out(input logic last, input logic [SW-1:0] s,
                                           input logic [DW-1:0] d);
    return {27'd0, last, s, d};
  endfunction

  // Sink ready pattern: 0 = always ready, 1 = toggle each cycle, 2 = random.
  initial forever begin
    @(posedge clk);
    #1;
    case (tr_mode)
      0:       m_tready = 1'b1;
      1:       m_tready = ~m_tready;
      default: m_tready = ($urandom_range(0, 3) != 0);
    endcase
  end

  // Output monitor: records handshakes and checks hold-while-stalled.
  initial begin
    logic        prev_stall;
    logic [63:0] prev_beat, cur;
    prev_stall = 1'b0;
    prev_beat  = '0;
    forever begin
      @(negedge clk);
      cur = pack_out(m_tlast, m_tstrb, m_tdata);
      if (!rst_n) begin
        prev_stall = 1'b0;
      end else begin
        if (prev_stall) begin
          check("hold_valid", 64'(m_tvalid), 64'(1));
          check("hold_beat", cur, prev_beat);
        end
        if (m_tvalid && m_tready) obs_q.push_back(cur);
        prev_stall = m_tvalid && !m_tready;
        prev_beat  = cur;
      end
    end
  end

  // Drives up to limit beats of in_q; optionally drops enable for 10 cycles after pause_after beats.
  task automatic send_pkt(input int n, input bit with_last, input int limit, input int pause_after);
    int i;
    int wait_cyc;
    bit hs;
    i = 0;
    while (i < limit) begin
      if ($urandom_range(0, 3) == 0) begin
        s_tvalid = 1'b0;
        @(posedge clk);
        #1;
      end
      s_tvalid = 1'b1;
      s_tdata  = in_q[i][DW-1:0];
      s_tstrb  = in_q[i][DW+SW-1:DW];
      s_tlast  = with_last && (i == n - 1);
      hs = 1'b0;
      wait_cyc = 0;
      while (!hs && wait_cyc < 200) begin
        @(negedge clk);
        hs = s_tready;
        @(posedge clk);
        #1;
        wait_cyc++;
      end
      if (!hs) begin
        check("s_accept_timeout", 64'(s_tready), 64'(1));
        i = limit;
      end else begin
        i++;
        if (i == pause_after) begin
          enable   = 1'b0;
          s_tdata  = in_q[i][DW-1:0];
          s_tstrb  = in_q[i][DW+SW-1:DW];
          s_tlast  = 1'b0;
          for (int k = 0; k < 10; k++) begin
            @(negedge clk);
            check("pause_tready", 64'(s_tready), 64'(0));
            @(posedge clk);
            #1;
          end
          enable = 1'b1;
        end
      end
    end
    s_tvalid = 1'b0;
    s_tlast  = 1'b0;
  endtask

  task automatic wait_idle();
    int c;
    c = 0;
    while (busy && c < 5000) begin
      @(posedge clk);
      #1;
      c++;
    end
    check("drain_done", 64'(busy), 64'(0));
  endtask

  task automatic compare_beats(input string tag, input int upto);
    check({tag, "_count"}, 64'(obs_q.size()), 64'(upto));
    for (int j = 0; j < upto && j < obs_q.size(); j++)
      check($sformatf("%s_beat%0d", tag, j), obs_q[j], exp_q[j]);
  endtask

  // One full packet: build input, capture, check latency and flags, replay against model.
  task automatic run_pkt(input string tag, input int n, input bit with_last, input int rep,
                         input int mode, input int pause_after, input bit seq);
    int stored;
    bit exp_ovf;
    logic [DW-1:0] d;
    logic [SW-1:0] s;
    in_q.delete();
    for (int k = 0; k < n + 1; k++) begin
      d = seq ? DW'(k + 1) : DW'($urandom);
      s = seq ? SW'(4'hF) : SW'($urandom_range(0, 15));
      in_q.push_back({28'd0, s, d});
    end
    stored  = (n < int'(MEM)) ? n : int'(MEM);
    exp_ovf = !(with_last && n <= int'(MEM));
    exp_q.delete();
    for (int r = 0; r <= rep; r++)
      for (int j = 0; j < stored; j++)
        exp_q.push_back(pack_out(j == stored - 1, in_q[j][DW+SW-1:DW], in_q[j][DW-1:0]));
    obs_q.delete();
    repeat_cnt = RW'(rep);
    tr_mode    = mode;
    enable     = 1'b1;
    send_pkt(n, with_last, stored, pause_after);
    enable = 1'b0;
    check({tag, "_pkt_len"}, 64'(pkt_len), 64'(stored));
    check({tag, "_busy_drain"}, 64'(busy), 64'(1));
    // Offer a further beat: it must stay stalled while the first output beat arrives.
    s_tvalid = 1'b1;
    s_tdata  = in_q[stored][DW-1:0];
    s_tstrb  = in_q[stored][DW+SW-1:DW];
    check({tag, "_lat0"}, 64'(m_tvalid), 64'(0));
    @(negedge clk);
    check({tag, "_stall_in1"}, 64'(s_tready), 64'(0));
    @(posedge clk);
    #1;
    check({tag, "_lat1"}, 64'(m_tvalid), 64'(0));
    @(negedge clk);
    check({tag, "_stall_in2"}, 64'(s_tready), 64'(0));
    @(posedge clk);
    #1;
    check({tag, "_lat2"}, 64'(m_tvalid), 64'(1));
    s_tvalid = 1'b0;
    wait_idle();
    check({tag, "_overflow"}, 64'(overflow), 64'(exp_ovf));
    compare_beats(tag, exp_q.size());
    @(posedge clk);
    #1;
  endtask

  initial begin
    int c;
    int n;
    repeat (2) @(posedge clk);
    #1;
    check("rst_tvalid", 64'(m_tvalid), 64'(0));
    check("rst_tlast", 64'(m_tlast), 64'(0));
    check("rst_tdata", 64'({m_tstrb, m_tdata}), 64'(0));
    check("rst_tready", 64'(s_tready), 64'(0));
    check("rst_busy", 64'(busy), 64'(0));
    check("rst_pkt_len", 64'(pkt_len), 64'(0));
    check("rst_overflow", 64'(overflow), 64'(0));
    rst_n = 1'b1;
    @(posedge clk);
    #1;

    run_pkt("t1", 8, 1'b1, 0, 0, -1, 1'b1);
    run_pkt("t2", 8, 1'b1, 2, 0, -1, 1'b1);
    run_pkt("t3", 70, 1'b0, 0, 0, -1, 1'b0);
    run_pkt("t4", 8, 1'b1, 1, 1, -1, 1'b0);
    run_pkt("t5", 6, 1'b1, 0, 0, 3, 1'b0);
    run_pkt("full64", 64, 1'b1, 0, 2, -1, 1'b0);
    run_pkt("len1", 1, 1'b1, 3, 2, -1, 1'b0);
    for (int k = 0; k < 4; k++) begin
      n = $urandom_range(2, 20);
      run_pkt($sformatf("rnd%0d", k), n, 1'b1, $urandom_range(0, 3), 2, -1, 1'b0);
    end

    // Reset in the middle of a replay.
    in_q.delete();
    for (int k = 0; k < 9; k++) in_q.push_back({28'd0, SW'($urandom_range(0, 15)), DW'($urandom)});
    exp_q.delete();
    for (int j = 0; j < 8; j++)
      exp_q.push_back(pack_out(j == 7, in_q[j][DW+SW-1:DW], in_q[j][DW-1:0]));
    obs_q.delete();
    repeat_cnt = '0;
    tr_mode    = 0;
    enable     = 1'b1;
    send_pkt(8, 1'b1, 8, -1);
    enable = 1'b0;
    c = 0;
    while (obs_q.size() < 4 && c < 200) begin
      @(posedge clk);
      #1;
      c++;
    end
    compare_beats("t6_pre", 4);
    rst_n = 1'b0;
    #1;
    check("t6_rst_tvalid", 64'(m_tvalid), 64'(0));
    check("t6_rst_busy", 64'(busy), 64'(0));
    check("t6_rst_tlast", 64'(m_tlast), 64'(0));
    check("t6_rst_pkt_len", 64'(pkt_len), 64'(0));
    repeat (3) @(posedge clk);
    #1;
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    check("t6_post_beats", 64'(obs_q.size()), 64'(4));
    run_pkt("t6_next", 8, 1'b1, 1, 0, -1, 1'b0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_asserts, n_fails);
    $finish;
  end

  // Global watchdog.
  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1, "watchdog expired");
  end

endmodule
